// File: rtl/spi_pkg.sv
// Shared types and defaults for the mode-0 SPI master shift engine.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} spi_state_t;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_CLK_DIV = 4;

   // {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer and sclk generator; sclk toggles only while run is high.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic run,
   output logic tick,
   output logic rise_tick,
   output logic fall_tick,
   output logic sclk
);

   // keep at least one bit so CLK_DIV=1 still elaborates
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick      = en && (cnt == LAST);
   assign rise_tick = run && tick && !sclk;
   assign fall_tick = run && tick && sclk;

   always_ff @(posedge clk) begin
      if (!rst || !en) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || !run) begin
         sclk <= 1'b0;
      end else if (tick) begin
         sclk <= ~sclk;
      end
   end

endmodule

// File: rtl/spi_master_byte.sv
// SPI master, mode 0, MSB first: sequencing FSM plus tx/rx shift registers.
//  state | meaning
//  IDLE  | cs_n high, waiting for st
//  LEAD  | cs_n low, MSB on mosi, one half-period before first sclk
//  SHIFT | DATA_W sclk periods, sample on rise, advance mosi on fall
//  TRAIL | sclk low, cs_n still low for one half-period
//  DONE  | cs_n high, dn pulse, rx_data updated
module spi_master_byte
   import spi_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic              busy,
   output logic              dn,
   output logic [DATA_W-1:0] rx_data
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   spi_state_t        state;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [BW-1:0]     bit_cnt;
   logic              tick;
   logic              rise_tick;
   logic              fall_tick;
   logic              tmr_en;
   logic              sclk_run;

   assign tmr_en   = (state == LEAD) || (state == SHIFT) || (state == TRAIL);
   assign sclk_run = (state == SHIFT);

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (tmr_en),
      .run       (sclk_run),
      .tick      (tick),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .sclk      (sclk)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cs_n    <= 1'b1;
         busy    <= 1'b0;
         dn      <= 1'b0;
         mosi    <= 1'b0;
         rx_data <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
      end else begin
         dn <= 1'b0;
         case (state)
            IDLE: begin
               if (st) begin
                  state   <= LEAD;
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
                  tx_sr   <= tx_data;
                  mosi    <= tx_data[DATA_W-1];
                  rx_sr   <= '0;
                  bit_cnt <= '0;
               end
            end
            LEAD: begin
               if (tick) state <= SHIFT;
            end
            SHIFT: begin
               if (rise_tick) rx_sr <= {rx_sr[DATA_W-2:0], miso};
               // the final falling edge leaves mosi on the LSB
               if (fall_tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     state <= TRAIL;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     mosi    <= tx_sr[DATA_W-2];
                     tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
                  end
               end
            end
            TRAIL: begin
               if (tick) begin
                  state   <= DONE;
                  cs_n    <= 1'b1;
                  dn      <= 1'b1;
                  rx_data <= rx_sr;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: default 8-bit/div-4 instance and a 16-bit/div-1 instance.
module tb_spi_master_byte;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        st0 = 1'b0;
   logic [7:0]  tx_data0 = '0;
   logic        loop0 = 1'b1;
   logic        miso_val0 = 1'b0;
   logic        miso0;
   logic        sclk0, mosi0, cs_n0, busy0, dn0;
   logic [7:0]  rx_data0;

   logic        st1 = 1'b0;
   logic [15:0] tx_data1 = '0;
   logic        miso1;
   logic        sclk1, mosi1, cs_n1, busy1, dn1;
   logic [15:0] rx_data1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign miso0 = loop0 ? mosi0 : miso_val0;
   assign miso1 = mosi1;

   spi_master_byte dut0 (
      .clk(clk), .rst(rst), .st(st0), .tx_data(tx_data0), .miso(miso0),
      .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0), .busy(busy0), .dn(dn0), .rx_data(rx_data0)
   );

   spi_master_byte #(.DATA_W(16), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .st(st1), .tx_data(tx_data1), .miso(miso1),
      .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .dn(dn1), .rx_data(rx_data1)
   );

   // Runs one transfer on dut0 for 90 cycles, optionally re-pulsing st, and collects observations.
   task automatic xfer0(input logic [7:0] tx, input int pulse_a, input int pulse_b,
                        output int dn_cyc, output int dn_count, output int rises,
                        output logic [7:0] bits, output int busy_gaps,
                        output int mosi_ones, output int cs_low_late);
      logic prev;
      dn_cyc = 0; dn_count = 0; rises = 0; bits = '0;
      busy_gaps = 0; mosi_ones = 0; cs_low_late = 0; prev = 1'b0;
      @(negedge clk);
      tx_data0 = tx;
      st0 = 1'b1;
      @(posedge clk);
      #1 st0 = 1'b0;
      for (int n = 1; n <= 90; n++) begin
         @(negedge clk);
         st0 = (n == pulse_a || n == pulse_b);
         if (sclk0 && !prev) begin
            rises++;
            bits = {bits[6:0], mosi0};
         end
         prev = sclk0;
         if (dn0) begin
            dn_count++;
            if (dn_cyc == 0) dn_cyc = n;
         end
         if (n <= 73 && !busy0) busy_gaps++;
         if (n >= 74 && !cs_n0) cs_low_late++;
         if (mosi0) mosi_ones++;
      end
      st0 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (cs_n0 !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n got=%b exp=1", cs_n0); end
      n_cmp++; if ({sclk0, mosi0, busy0, dn0} !== 4'b0000) begin n_bad++; $display("FAIL reset_outs got=%b exp=0000", {sclk0, mosi0, busy0, dn0}); end
      n_cmp++; if (rx_data0 !== 8'h00) begin n_bad++; $display("FAIL reset_rx got=%h exp=00", rx_data0); end
      n_cmp++; if ({cs_n1, sclk1, busy1, dn1, rx_data1} !== {4'b1000, 16'h0000}) begin n_bad++; $display("FAIL reset_dut1 got=%b exp=1000_0", {cs_n1, sclk1, busy1, dn1, rx_data1}); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_loopback_a5();
      int dc, cnt, r, bg, mo, cl;
      logic [7:0] b;
      loop0 = 1'b1;
      xfer0(8'hA5, -1, -1, dc, cnt, r, b, bg, mo, cl);
      n_cmp++; if (dc !== 73) begin n_bad++; $display("FAIL a5_dn_cycle got=%0d exp=73", dc); end
      n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL a5_dn_count got=%0d exp=1", cnt); end
      n_cmp++; if (r !== 8) begin n_bad++; $display("FAIL a5_rises got=%0d exp=8", r); end
      n_cmp++; if (b !== 8'hA5) begin n_bad++; $display("FAIL a5_mosi_bits got=%h exp=a5", b); end
      n_cmp++; if (rx_data0 !== 8'hA5) begin n_bad++; $display("FAIL a5_rx got=%h exp=a5", rx_data0); end
      n_cmp++; if (bg !== 0) begin n_bad++; $display("FAIL a5_busy_gaps got=%0d exp=0", bg); end
   endtask

   task automatic test_reset_mid_shift();
      int dcount, cslow;
      loop0 = 1'b1;
      @(negedge clk);
      tx_data0 = 8'hFF;
      st0 = 1'b1;
      @(posedge clk);
      #1 st0 = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if ({cs_n0, sclk0, busy0, dn0} !== 4'b1000) begin n_bad++; $display("FAIL abort_outs got=%b exp=1000", {cs_n0, sclk0, busy0, dn0}); end
      n_cmp++; if (rx_data0 !== 8'h00) begin n_bad++; $display("FAIL abort_rx got=%h exp=00", rx_data0); end
      @(negedge clk);
      rst = 1'b1;
      dcount = 0; cslow = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (dn0) dcount++;
         if (!cs_n0) cslow++;
      end
      n_cmp++; if ({dcount, cslow} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL abort_quiet got dn=%0d cs_low=%0d exp=0,0", dcount, cslow); end
   endtask

   task automatic test_miso_high();
      int dc, cnt, r, bg, mo, cl;
      logic [7:0] b;
      loop0 = 1'b0;
      miso_val0 = 1'b1;
      xfer0(8'h00, -1, -1, dc, cnt, r, b, bg, mo, cl);
      n_cmp++; if (rx_data0 !== 8'hFF) begin n_bad++; $display("FAIL ones_rx got=%h exp=ff", rx_data0); end
      n_cmp++; if (mo !== 0) begin n_bad++; $display("FAIL ones_mosi_high_cycles got=%0d exp=0", mo); end
      n_cmp++; if (r !== 8) begin n_bad++; $display("FAIL ones_rises got=%0d exp=8", r); end
      loop0 = 1'b1;
   endtask

   task automatic test_st_ignored();
      int dc, cnt, r, bg, mo, cl;
      logic [7:0] b;
      loop0 = 1'b1;
      xfer0(8'h5A, 10, 72, dc, cnt, r, b, bg, mo, cl);
      n_cmp++; if ({dc, cnt} !== {32'd73, 32'd1}) begin n_bad++; $display("FAIL ign_dn got cyc=%0d cnt=%0d exp=73,1", dc, cnt); end
      n_cmp++; if (bg !== 0) begin n_bad++; $display("FAIL ign_busy_gaps got=%0d exp=0", bg); end
      n_cmp++; if (cl !== 0) begin n_bad++; $display("FAIL ign_no_restart got=%0d exp=0", cl); end
      n_cmp++; if (rx_data0 !== 8'h5A) begin n_bad++; $display("FAIL ign_rx got=%h exp=5a", rx_data0); end
      xfer0(8'h81, 73, -1, dc, cnt, r, b, bg, mo, cl);
      n_cmp++; if ({cnt, cl} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL ign_done_st got cnt=%0d cs_low=%0d exp=1,0", cnt, cl); end
   endtask

   task automatic test_back_to_back();
      int d1, d2;
      logic [7:0] rx_first, rx_mid, rx_second;
      logic [2:0] gap, restart;
      loop0 = 1'b1;
      d1 = 0; d2 = 0; rx_first = '0; rx_mid = '0; rx_second = '0; gap = '0; restart = '0;
      @(negedge clk);
      tx_data0 = 8'h3C;
      st0 = 1'b1;
      @(posedge clk);
      #1 tx_data0 = 8'hC3;
      for (int n = 1; n <= 160; n++) begin
         @(negedge clk);
         if (dn0) begin
            if (d1 == 0) begin d1 = n; rx_first = rx_data0; end
            else if (d2 == 0) begin d2 = n; rx_second = rx_data0; end
         end
         if (n == 74) gap = {cs_n0, busy0, dn0};
         if (n == 75) restart = {cs_n0, busy0, dn0};
         if (n == 100) rx_mid = rx_data0;
         if (n == 147) st0 = 1'b0;
      end
      st0 = 1'b0;
      n_cmp++; if ({d1, d2} !== {32'd73, 32'd147}) begin n_bad++; $display("FAIL b2b_dn_cycles got=%0d,%0d exp=73,147", d1, d2); end
      n_cmp++; if (gap !== 3'b100) begin n_bad++; $display("FAIL b2b_idle_gap got=%b exp=100", gap); end
      n_cmp++; if (restart !== 3'b010) begin n_bad++; $display("FAIL b2b_restart got=%b exp=010", restart); end
      n_cmp++; if (rx_first !== 8'h3C) begin n_bad++; $display("FAIL b2b_rx_first got=%h exp=3c", rx_first); end
      n_cmp++; if (rx_mid !== 8'h3C) begin n_bad++; $display("FAIL b2b_rx_hold got=%h exp=3c", rx_mid); end
      n_cmp++; if (rx_second !== 8'hC3) begin n_bad++; $display("FAIL b2b_rx_second got=%h exp=c3", rx_second); end
   endtask

   task automatic test_div1_16bit();
      int dc, cnt, rises, toggles;
      logic prev;
      dc = 0; cnt = 0; rises = 0; toggles = 0; prev = 1'b0;
      @(negedge clk);
      tx_data1 = 16'h8001;
      st1 = 1'b1;
      @(posedge clk);
      #1 st1 = 1'b0;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (sclk1 !== prev) toggles++;
         if (sclk1 && !prev) rises++;
         prev = sclk1;
         if (dn1) begin
            cnt++;
            if (dc == 0) dc = n;
         end
      end
      n_cmp++; if ({dc, cnt} !== {32'd35, 32'd1}) begin n_bad++; $display("FAIL d1_dn got cyc=%0d cnt=%0d exp=35,1", dc, cnt); end
      n_cmp++; if ({rises, toggles} !== {32'd16, 32'd32}) begin n_bad++; $display("FAIL d1_sclk got rises=%0d toggles=%0d exp=16,32", rises, toggles); end
      n_cmp++; if (rx_data1 !== 16'h8001) begin n_bad++; $display("FAIL d1_rx got=%h exp=8001", rx_data1); end
   endtask

   initial begin
      test_reset();
      test_loopback_a5();
      test_reset_mid_shift();
      test_miso_high();
      test_st_ignored();
      test_back_to_back();
      test_div1_16bit();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
